// File: rtl/core_types_pkg.sv
// Shared core types: memory-port arbiter FSM encodings and side-select constants.
package core_types;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_DONE_I = 3'd3,
    ARB_DONE_D = 3'd4
  } arb_state_t;

  localparam logic ARB_SEL_I = 1'b0;
  localparam logic ARB_SEL_D = 1'b1;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts non-acknowledged bus cycles; expired stays high once TIMEOUT cycles have elapsed.
module bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_count
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;

      // Saturates at TIMEOUT so expired cannot wrap back low.
      always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (enable && (cnt != CW'(TIMEOUT))) cnt <= cnt + CW'(1);
      end

      assign expired = (cnt == CW'(TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Data side wins conflicts; killed fetches complete on the bus but produce no strobe.
module mem_port_arbiter
  import core_types::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_kill,
  output logic                i_valid,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_mask,
  output logic                d_valid,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_mask,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output arb_state_t          state
);

  // Handshake: a request is held stable until its side sees valid/err (or kill
  // for fetch); bus_req is held until a one-cycle bus_ack, or until timeout.

  localparam int MASK_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  logic accept_i, accept_d, busy, sel, expired;
  logic kill_q, err_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q, i_rdata_q, d_rdata_q;
  logic [MASK_W-1:0] bus_mask_q;

  assign busy  = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
  assign sel   = (state_q == ARB_BUSY_D) ? ARB_SEL_D : ARB_SEL_I;
  assign state = state_q;

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .enable  (busy && !bus_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept_i = 1'b0;
    accept_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (d_req) begin
          state_d  = ARB_BUSY_D;
          accept_d = 1'b1;
        end else if (i_req && !i_kill) begin
          state_d  = ARB_BUSY_I;
          accept_i = 1'b1;
        end
      end
      ARB_BUSY_I: if (bus_ack || expired) state_d = ARB_DONE_I;
      ARB_BUSY_D: if (bus_ack || expired) state_d = ARB_DONE_D;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_mask_q  <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      kill_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept_d) begin
        bus_we_q    <= d_we;
        bus_addr_q  <= d_addr;
        bus_wdata_q <= d_wdata;
        bus_mask_q  <= d_mask;
      end else if (accept_i) begin
        bus_we_q    <= 1'b0;
        bus_addr_q  <= i_addr;
        bus_wdata_q <= '0;
        bus_mask_q  <= '1;
      end
      // Ack wins over a timeout expiring in the same cycle.
      if (busy && (bus_ack || expired)) begin
        err_q <= !bus_ack;
        if (sel == ARB_SEL_D) d_rdata_q <= bus_ack ? bus_rdata : '0;
        else                  i_rdata_q <= bus_ack ? bus_rdata : '0;
      end
      if (state_q == ARB_DONE_I)                   kill_q <= 1'b0;
      else if ((state_q == ARB_BUSY_I) && i_kill) kill_q <= 1'b1;
    end
  end

  assign bus_req   = busy && !expired;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_mask  = bus_mask_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign i_valid = (state_q == ARB_DONE_I) && !kill_q && !i_kill && !err_q;
  assign i_err   = (state_q == ARB_DONE_I) && !kill_q && !i_kill && err_q;
  assign d_valid = (state_q == ARB_DONE_D) && !err_q;
  assign d_err   = (state_q == ARB_DONE_D) && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=4 and hand-computed expectations.
module tb_mem_port_arbiter;
  import core_types::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_kill, d_req, d_we, bus_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, bus_rdata;
  logic [MW-1:0] d_mask;
  logic          i_valid, i_err, d_valid, d_err, bus_req, bus_we;
  logic [DW-1:0] i_rdata, d_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic [MW-1:0] bus_mask;
  arb_state_t    state;

  int total  = 0;
  int passed = 0;
  int iv_cnt = 0, ie_cnt = 0, dv_cnt = 0, de_cnt = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_valid(i_valid), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_mask(bus_mask), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // strobe counters, sampled mid-cycle
  always @(negedge clk) begin
    if (i_valid) iv_cnt++;
    if (i_err)   ie_cnt++;
    if (d_valid) dv_cnt++;
    if (d_err)   de_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 0; i_kill = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_mask = '0;
    bus_ack = 0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (state !== ARB_IDLE) $display("FAIL reset_state got %0d exp %0d", state, ARB_IDLE); else passed++;
    total++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_mask} !== '0) $display("FAIL reset_bus got %0h exp 0", {bus_req, bus_we, bus_addr, bus_wdata, bus_mask}); else passed++;
    total++; if ({i_valid, i_err, d_valid, d_err, i_rdata, d_rdata} !== '0) $display("FAIL reset_side got %0h exp 0", {i_valid, i_err, d_valid, d_err, i_rdata, d_rdata}); else passed++;
  endtask

  task automatic test_single_fetch();
    int v0;
    v0 = iv_cnt;
    i_req = 1; i_addr = 32'h100;
    tick();
    total++; if (bus_req !== 1'b1) $display("FAIL fetch_bus_req got %0b exp 1", bus_req); else passed++;
    total++; if (bus_addr !== 32'h100) $display("FAIL fetch_bus_addr got %0h exp 100", bus_addr); else passed++;
    total++; if ({bus_we, bus_mask} !== 5'b0_1111) $display("FAIL fetch_we_mask got %0b exp 01111", {bus_we, bus_mask}); else passed++;
    tick(); tick();
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    tick();
    bus_ack = 0;
    total++; if (i_valid !== 1'b1) $display("FAIL fetch_i_valid got %0b exp 1", i_valid); else passed++;
    total++; if (i_rdata !== 32'hDEADBEEF) $display("FAIL fetch_i_rdata got %0h exp deadbeef", i_rdata); else passed++;
    total++; if (bus_req !== 1'b0) $display("FAIL fetch_done_bus_req got %0b exp 0", bus_req); else passed++;
    tick();
    total++; if (bus_req !== 1'b0) $display("FAIL fetch_no_reissue got %0b exp 0", bus_req); else passed++;
    i_req = 0;
    tick();
    total++; if (iv_cnt - v0 !== 1) $display("FAIL fetch_pulse_count got %0d exp 1", iv_cnt - v0); else passed++;
    total++; if (state !== ARB_IDLE) $display("FAIL fetch_idle got %0d exp %0d", state, ARB_IDLE); else passed++;
  endtask

  task automatic test_priority();
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55; d_mask = 4'b0001;
    tick();
    total++; if (state !== ARB_BUSY_D) $display("FAIL prio_state got %0d exp %0d", state, ARB_BUSY_D); else passed++;
    total++; if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b1, 32'h2000}) $display("FAIL prio_store_addr got %0h exp %0h", {bus_req, bus_we, bus_addr}, {1'b1, 1'b1, 32'h2000}); else passed++;
    total++; if ({bus_wdata, bus_mask} !== {32'h55, 4'b0001}) $display("FAIL prio_store_data got %0h exp %0h", {bus_wdata, bus_mask}, {32'h55, 4'b0001}); else passed++;
    bus_ack = 1; bus_rdata = 32'hAAAA5555;
    tick();
    bus_ack = 0;
    total++; if ({d_valid, i_valid} !== 2'b10) $display("FAIL prio_d_valid got %0b exp 10", {d_valid, i_valid}); else passed++;
    d_req = 0; d_we = 0;
    tick();
    tick();
    total++; if ({state, bus_addr, bus_we, bus_mask} !== {ARB_BUSY_I, 32'h300, 1'b0, 4'hF}) $display("FAIL prio_fetch_issue got %0h exp %0h", {state, bus_addr, bus_we, bus_mask}, {ARB_BUSY_I, 32'h300, 1'b0, 4'hF}); else passed++;
    bus_ack = 1; bus_rdata = 32'h12345678;
    tick();
    bus_ack = 0;
    total++; if ({i_valid, i_rdata} !== {1'b1, 32'h12345678}) $display("FAIL prio_fetch_done got %0h exp %0h", {i_valid, i_rdata}, {1'b1, 32'h12345678}); else passed++;
    i_req = 0;
    tick();
  endtask

  task automatic test_kill();
    int v0;
    v0 = iv_cnt;
    i_req = 1; i_addr = 32'h400;
    tick();
    tick();
    i_kill = 1; i_req = 0;
    tick();
    i_kill = 0;
    tick();
    total++; if (bus_req !== 1'b1) $display("FAIL kill_bus_held got %0b exp 1", bus_req); else passed++;
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_ack = 0;
    total++; if ({state, i_valid} !== {ARB_DONE_I, 1'b0}) $display("FAIL kill_no_valid got %0h exp %0h", {state, i_valid}, {ARB_DONE_I, 1'b0}); else passed++;
    total++; if (i_rdata !== 32'hCAFEF00D) $display("FAIL kill_rdata got %0h exp cafef00d", i_rdata); else passed++;
    tick();
    i_req = 1; i_addr = 32'h500;
    tick();
    total++; if ({bus_req, bus_addr} !== {1'b1, 32'h500}) $display("FAIL kill_next_issue got %0h exp %0h", {bus_req, bus_addr}, {1'b1, 32'h500}); else passed++;
    bus_ack = 1; bus_rdata = 32'h0000BEEF;
    tick();
    bus_ack = 0;
    total++; if ({i_valid, i_rdata} !== {1'b1, 32'h0000BEEF}) $display("FAIL kill_next_done got %0h exp %0h", {i_valid, i_rdata}, {1'b1, 32'h0000BEEF}); else passed++;
    i_req = 0;
    tick();
    total++; if (iv_cnt - v0 !== 1) $display("FAIL kill_pulse_count got %0d exp 1", iv_cnt - v0); else passed++;
  endtask

  task automatic test_timeout();
    int high_n, err_at, v0;
    high_n = 0; err_at = -1; v0 = dv_cnt;
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    tick();
    for (int k = 0; k < 8; k++) begin
      if (bus_req) high_n++;
      if (d_err && err_at < 0) begin
        err_at = k;
        total++; if ({d_rdata, d_valid} !== '0) $display("FAIL to_rdata_zero got %0h exp 0", {d_rdata, d_valid}); else passed++;
        d_req = 0;
      end
      tick();
    end
    d_req = 0;
    total++; if (high_n !== 4) $display("FAIL to_req_cycles got %0d exp 4", high_n); else passed++;
    total++; if (err_at !== 5) $display("FAIL to_err_cycle got %0d exp 5", err_at); else passed++;
    total++; if (dv_cnt - v0 !== 0) $display("FAIL to_no_valid got %0d exp 0", dv_cnt - v0); else passed++;
    total++; if (state !== ARB_IDLE) $display("FAIL to_idle got %0d exp %0d", state, ARB_IDLE); else passed++;
  endtask

  task automatic test_reset_mid_access();
    int v0;
    v0 = dv_cnt;
    d_req = 1; d_we = 0; d_addr = 32'h4000;
    tick();
    tick();
    rst = 1; d_req = 0;
    tick();
    rst = 0; bus_ack = 1; bus_rdata = 32'h99;
    total++; if (state !== ARB_IDLE) $display("FAIL rst_mid_state got %0d exp %0d", state, ARB_IDLE); else passed++;
    total++; if ({bus_req, bus_we, bus_addr, bus_wdata, bus_mask, i_rdata, d_rdata, i_valid, d_valid, i_err, d_err} !== '0) $display("FAIL rst_mid_outputs got nonzero exp 0"); else passed++;
    tick();
    bus_ack = 0;
    total++; if ({state, d_valid, d_rdata} !== {ARB_IDLE, 1'b0, 32'h0}) $display("FAIL rst_stale_ack got %0h exp %0h", {state, d_valid, d_rdata}, {ARB_IDLE, 1'b0, 32'h0}); else passed++;
    tick();
    total++; if (dv_cnt - v0 !== 0) $display("FAIL rst_no_strobe got %0d exp 0", dv_cnt - v0); else passed++;
  endtask

  task automatic test_ack_at_timeout();
    d_req = 1; d_we = 0; d_addr = 32'h5000;
    tick();
    repeat (4) tick();
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    tick();
    bus_ack = 0;
    total++; if ({d_valid, d_err} !== 2'b10) $display("FAIL ackto_strobes got %0b exp 10", {d_valid, d_err}); else passed++;
    total++; if (d_rdata !== 32'h0BADF00D) $display("FAIL ackto_rdata got %0h exp 0badf00d", d_rdata); else passed++;
    d_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_kill();
    test_timeout();
    test_reset_mid_access();
    test_ack_at_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
